// File: rtl/cosim_commit_tracer.sv
// Non-blocking commit tracer for lock-step co-simulation: captures retired
// instructions once START_PC is seen and queues them in a small FIFO for the checker.
module cosim_commit_tracer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [63:0] START_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic        stall_exe,
  input  logic [63:0] pc,
  input  logic [31:0] instr,
  input  logic        xreg_we,
  input  logic [4:0]  xreg_dest,
  input  logic        freg_we,
  input  logic [4:0]  freg_dest,
  input  logic [63:0] commit_data,
  input  logic        excep_valid,
  input  logic [63:0] excep_cause,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [63:0] rec_pc,
  output logic [31:0] rec_instr,
  output logic [1:0]  rec_kind,
  output logic [4:0]  rec_dst,
  output logic [63:0] rec_data,
  output logic [31:0] rec_seq,
  output logic        armed,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_XREG = 2'b01,
    KIND_FREG = 2'b10,
    KIND_EXCP = 2'b11
  } kind_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    kind_e       kind;
    logic [4:0]  dst;
    logic [63:0] data;
    logic [31:0] seq;
  } rec_t;

  logic          armed_q, armed_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic [31:0]   seq_q, seq_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  rec_t          rec_mem_q [DEPTH];
  rec_t          entry_d;
  rec_t          head;
  logic          capture, log_event, full, pop, push, drop;

  always_comb begin
    capture   = commit && (!stall_exe || excep_valid);
    // The arming capture is itself logged, so armed_q alone is not enough here.
    log_event = capture && (armed_q || (pc == START_PC));
    full      = (count_q == FULL_CNT);
    pop       = (count_q != '0) && rec_ready;
    push      = log_event && (!full || pop);
    drop      = log_event && !push;

    entry_d       = '0;
    entry_d.pc    = pc;
    entry_d.instr = instr;
    entry_d.seq   = seq_q;
    entry_d.kind  = KIND_NONE;
    if (excep_valid) begin
      entry_d.kind = KIND_EXCP;
      entry_d.data = excep_cause;
    end else if (xreg_we && (xreg_dest != '0)) begin
      entry_d.kind = KIND_XREG;
      entry_d.dst  = xreg_dest;
      entry_d.data = commit_data;
    end else if (freg_we) begin
      entry_d.kind = KIND_FREG;
      entry_d.dst  = freg_dest;
      entry_d.data = commit_data;
    end

    armed_d      = armed_q || log_event;
    seq_d        = log_event ? seq_q + 32'd1 : seq_q;
    overflow_d   = overflow_q || drop;
    drop_count_d = (drop && (drop_count_q != '1)) ? drop_count_q + 16'd1 : drop_count_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q      <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      seq_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      armed_q      <= armed_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      seq_q        <= seq_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      rec_mem_q[wr_ptr_q] <= entry_d;
    end
  end

  always_comb begin
    head      = rec_mem_q[rd_ptr_q];
    rec_valid = (count_q != '0);
    rec_pc    = rec_valid ? head.pc    : '0;
    rec_instr = rec_valid ? head.instr : '0;
    rec_kind  = rec_valid ? head.kind  : '0;
    rec_dst   = rec_valid ? head.dst   : '0;
    rec_data  = rec_valid ? head.data  : '0;
    rec_seq   = rec_valid ? head.seq   : '0;
  end

  assign armed      = armed_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_cosim_commit_tracer.sv
// Directed bench for cosim_commit_tracer: a queue-based reference model checked every
// cycle, plus literal expectations for the arming, kind, exception, overflow and reset cases.
module tb_cosim_commit_tracer;

  localparam int unsigned DEPTH    = 8;
  localparam logic [63:0] START_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, commit, stall_exe, xreg_we, freg_we, excep_valid, rec_ready;
  logic [63:0] pc, commit_data, excep_cause;
  logic [31:0] instr;
  logic [4:0]  xreg_dest, freg_dest;
  logic        rec_valid, armed, overflow;
  logic [63:0] rec_pc, rec_data;
  logic [31:0] rec_instr, rec_seq;
  logic [1:0]  rec_kind;
  logic [4:0]  rec_dst;
  logic [15:0] drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cosim_commit_tracer #(.DEPTH(DEPTH), .START_PC(START_PC)) dut (
    .clk(clk), .rst(rst), .commit(commit), .stall_exe(stall_exe), .pc(pc), .instr(instr),
    .xreg_we(xreg_we), .xreg_dest(xreg_dest), .freg_we(freg_we), .freg_dest(freg_dest),
    .commit_data(commit_data), .excep_valid(excep_valid), .excep_cause(excep_cause),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pc(rec_pc), .rec_instr(rec_instr),
    .rec_kind(rec_kind), .rec_dst(rec_dst), .rec_data(rec_data), .rec_seq(rec_seq),
    .armed(armed), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of records, event number, loss bookkeeping.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [1:0]  kind;
    logic [4:0]  dst;
    logic [63:0] data;
    logic [31:0] seq;
  } mrec_t;

  mrec_t       mq[$];
  logic        m_armed = 1'b0;
  logic        m_ovf = 1'b0;
  int unsigned m_drops = 0;
  logic [31:0] m_seq = '0;

  always @(posedge clk) begin
    mrec_t r;
    logic  took, retired;
    if (rst) begin
      mq.delete();
      m_armed = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
      m_seq   = '0;
    end else begin
      retired = (mq.size() != 0) && rec_ready;
      took    = commit && (!stall_exe || excep_valid);
      if (took && pc == START_PC) m_armed = 1'b1;
      if (retired) void'(mq.pop_front());
      if (took && m_armed) begin
        r.pc = pc; r.instr = instr; r.seq = m_seq;
        if (excep_valid) begin
          r.kind = 2'd3; r.dst = 5'd0; r.data = excep_cause;
        end else if (xreg_we && xreg_dest != 5'd0) begin
          r.kind = 2'd1; r.dst = xreg_dest; r.data = commit_data;
        end else if (freg_we) begin
          r.kind = 2'd2; r.dst = freg_dest; r.data = commit_data;
        end else begin
          r.kind = 2'd0; r.dst = 5'd0; r.data = 64'd0;
        end
        if (mq.size() < DEPTH) mq.push_back(r);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
        m_seq = m_seq + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    mrec_t h;
    logic  v;
    v = (mq.size() != 0);
    if (v) h = mq[0];
    else begin
      h.pc = '0; h.instr = '0; h.kind = '0; h.dst = '0; h.data = '0; h.seq = '0;
    end
    chk("m_valid", rec_valid, v);
    chk("m_pc", rec_pc, h.pc);
    chk("m_instr", rec_instr, h.instr);
    chk("m_kind", rec_kind, h.kind);
    chk("m_dst", rec_dst, h.dst);
    chk("m_data", rec_data, h.data);
    chk("m_seq", rec_seq, h.seq);
    chk("m_armed", armed, m_armed);
    chk("m_overflow", overflow, m_ovf);
    chk("m_drop", drop_count, m_drops[15:0]);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [63:0] p, input logic xwe, input logic [4:0] xd,
                       input logic fwe, input logic [4:0] fd, input logic [63:0] d,
                       input logic st, input logic ev, input logic [63:0] cause);
    commit = 1'b1; pc = p; instr = {p[15:0], 16'h0013};
    xreg_we = xwe; xreg_dest = xd; freg_we = fwe; freg_dest = fd; commit_data = d;
    stall_exe = st; excep_valid = ev; excep_cause = cause;
    tick();
    commit = 1'b0; stall_exe = 1'b0; excep_valid = 1'b0; xreg_we = 1'b0; freg_we = 1'b0;
  endtask

  task automatic plain(input logic [63:0] p);
    drive(p, 1'b1, 5'd10, 1'b0, 5'd0, p ^ 64'hA5, 1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    rst = 1'b1; commit = 1'b0; stall_exe = 1'b0; pc = '0; instr = '0;
    xreg_we = 1'b0; xreg_dest = '0; freg_we = 1'b0; freg_dest = '0; commit_data = '0;
    excep_valid = 1'b0; excep_cause = '0; rec_ready = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_armed", armed, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    rst = 1'b0;

    // Arming: pre-START_PC commits are invisible.
    rec_ready = 1'b1;
    plain(64'h1000);
    chk("pre_arm_valid", rec_valid, 1'b0);
    plain(64'h1004);
    chk("pre_arm_armed", armed, 1'b0);
    drive(START_PC, 1'b1, 5'd1, 1'b0, 5'd0, 64'h55, 1'b0, 1'b0, 64'd0);
    chk("arm_valid", rec_valid, 1'b1);
    chk("arm_pc", rec_pc, 64'h8000_0000);
    chk("arm_seq", rec_seq, 32'd0);
    chk("arm_armed", armed, 1'b1);
    chk("arm_kind", rec_kind, 2'b01);
    chk("arm_data", rec_data, 64'h55);
    tick();
    chk("arm_popped", rec_valid, 1'b0);

    // x0 write loses to the FP write.
    drive(64'h8000_0004, 1'b1, 5'd0, 1'b1, 5'd3, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0, 64'd0);
    chk("wk_kind", rec_kind, 2'b10);
    chk("wk_dst", rec_dst, 5'd3);
    chk("wk_data", rec_data, 64'h3FF0_0000_0000_0000);
    chk("wk_seq", rec_seq, 32'd1);
    tick();

    // Exception is captured despite the stall; plain stall is not.
    drive(64'h8000_0008, 1'b1, 5'd7, 1'b0, 5'd0, 64'hDEAD, 1'b1, 1'b1, 64'h8000_0000_0000_0007);
    chk("ex_kind", rec_kind, 2'b11);
    chk("ex_dst", rec_dst, 5'd0);
    chk("ex_data", rec_data, 64'h8000_0000_0000_0007);
    chk("ex_seq", rec_seq, 32'd2);
    tick();
    chk("ex_popped", rec_valid, 1'b0);
    drive(64'h8000_000C, 1'b1, 5'd7, 1'b0, 5'd0, 64'hBEEF, 1'b1, 1'b0, 64'd0);
    chk("stall_no_rec", rec_valid, 1'b0);

    // Reset with three records buffered.
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) plain(64'h8000_0010 + 64'(4 * i));
    chk("rm_head_seq", rec_seq, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_valid", rec_valid, 1'b0);
    chk("rm_pc", rec_pc, 64'd0);
    chk("rm_armed", armed, 1'b0);
    plain(64'h8000_0004);
    chk("rm_not_rearmed", rec_valid, 1'b0);

    // Full FIFO with simultaneous pop accepts the push.
    for (int i = 0; i < 8; i++) plain(START_PC + 64'(4 * i));
    chk("ff_head_seq", rec_seq, 32'd0);
    rec_ready = 1'b1;
    plain(START_PC + 64'h20);
    chk("ff_overflow", overflow, 1'b0);
    chk("ff_drop", drop_count, 16'd0);
    chk("ff_head_seq2", rec_seq, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("ff_last_seq", rec_seq, 32'd8);
    chk("ff_last_valid", rec_valid, 1'b1);
    tick();
    chk("ff_empty", rec_valid, 1'b0);

    // Overflow: 10 captures into 8 slots.
    rst = 1'b1; rec_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) plain(START_PC + 64'(4 * i));
    chk("ov_flag", overflow, 1'b1);
    chk("ov_drop", drop_count, 16'd2);
    chk("ov_head_seq", rec_seq, 32'd0);
    rec_ready = 1'b1;
    plain(START_PC + 64'h100);
    chk("ov_head_seq2", rec_seq, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("ov_ninth_seq", rec_seq, 32'd10);
    chk("ov_ninth_pc", rec_pc, START_PC + 64'h100);
    tick();
    chk("ov_empty", rec_valid, 1'b0);
    chk("ov_sticky", overflow, 1'b1);
    chk("ov_drop_hold", drop_count, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cosim_commit_tracer.md
COSIM_COMMIT_TRACER -- requirements
Module: cosim_commit_tracer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; must be a power of two and at least 2.
REQ-002 SHALL have parameter START_PC, default 64'h80000000, the first PC that arms tracing.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1); one clock; reset is synchronous and active-high.
REQ-004 SHALL have inputs:
- commit (1): instruction commit strobe.
- stall_exe (1): pipeline execute stall.
- pc (64): committing PC, already sign-extended.
- instr (32): original instruction word.
REQ-005 SHALL have inputs:
- xreg_we (1), xreg_dest (5): integer register write.
- freg_we (1), freg_dest (5): FP register write.
- commit_data (64): write-back value.
REQ-006 SHALL have inputs excep_valid (1), committing exception/interrupt, and excep_cause (64), its mcause.
REQ-007 SHALL have record inputs/outputs:
- rec_valid out 1: head record available.
- rec_ready in 1: consumer accepts.
- rec_pc out 64.
- rec_instr out 32.
- rec_kind out 2: 00 none, 01 xreg, 10 freg, 11 exception.
- rec_dst out 5.
- rec_data out 64.
- rec_seq out 32.
REQ-008 SHALL have status outputs:
- armed out 1: tracing active.
- overflow out 1: sticky loss flag.
- drop_count out 16: lost records.

Function
REQ-009 SHALL define capture = (commit && !stall_exe) || (commit && excep_valid), evaluated each clk edge.
REQ-010 SHALL set armed on the first capture with pc == START_PC; that event is itself recorded; captures before arming are ignored and do not advance seq.
REQ-011 SHALL build the record kind with priority:
- excep_valid -> 11, rec_data = excep_cause, rec_dst = 0.
- else xreg_we && xreg_dest != 0 -> 01, rec_dst = xreg_dest.
- else freg_we -> 10, rec_dst = freg_dest.
- else -> 00, rec_dst = 0, rec_data = 0.
REQ-012 SHALL assign rec_seq from a 32-bit event counter that increments on every armed capture, including dropped ones, wrapping 32'hFFFFFFFF -> 0; a gap in rec_seq reveals loss.
REQ-013 SHALL push a record into the FIFO on an armed capture; it becomes visible on rec_* with rec_valid=1 no earlier than one cycle after the capture edge (one-cycle latency when the FIFO was empty).
REQ-014 SHALL pop the head on rec_valid && rec_ready; rec_* SHALL hold stable while rec_valid=1 && rec_ready=0.
REQ-015 SHALL drive every rec_* output to 0 while rec_valid=0.
REQ-016 SHALL use DEPTH-entry storage with wrapping read/write pointers and an occupancy count 0..DEPTH.
REQ-017 SHALL handle a full FIFO with a pop in the same cycle by accepting the push; occupancy stays DEPTH.
REQ-018 SHALL handle an empty FIFO with a push in the same cycle (no bypass) by setting rec_valid the next cycle.
REQ-019 SHALL handle a full FIFO with an armed capture and no pop by discarding the record, setting overflow=1 until reset, and incrementing drop_count, saturating at 16'hFFFF.
REQ-020 SHALL treat the tracer as non-blocking: no output feeds back to the core pipeline.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, clear armed, overflow, drop_count, seq, pointers and occupancy; rec_valid and every rec_* output read 0 the following cycle.
REQ-022 SHALL discard all buffered records on reset mid-operation; after reset, tracing re-arms only on START_PC.

Verification
REQ-023 SHALL cover the arming scenario: commits at 0x1000 and 0x1004, then 0x80000000 with rec_ready=1 -> first record pc=0x80000000, seq=0, armed=1; earlier commits never appear.
REQ-024 SHALL cover the write-kind scenario: armed; commit with xreg_we=1, dest=0, freg_we=1, freg_dest=3, data=0x3FF0000000000000 -> kind=10, dst=3, data=0x3FF0000000000000.
REQ-025 SHALL cover the exception scenario: armed; commit=1, stall_exe=1, excep_valid=1, cause=0x8000000000000007 -> one record, kind=11, data=0x8000000000000007; the same stall without excep_valid -> no record.
REQ-026 SHALL cover the overflow scenario: DEPTH=8, rec_ready=0, 10 armed captures -> 8 records retained with seq 0..7, overflow=1, drop_count=2; then release rec_ready=1 and one more capture -> 9th record seq=10.
REQ-027 SHALL cover the full-FIFO simultaneous scenario: FIFO full, rec_ready=1 and a capture in the same cycle -> push accepted, overflow stays 0, occupancy stays 8.
REQ-028 SHALL cover the reset mid-operation scenario: 3 records buffered, rst for 1 cycle -> rec_valid=0, seq restarts at 0 after the next START_PC.
